fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_pkg.sv | 11 +
 rtl/rr_pick.sv | 27 ++
 rtl/fifo_wr_arb.sv | 119 +++++++++++
 tb/tb_fifo_wr_arb.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the fifo write arbiter
package fifo_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin priority search: first set request at or above ptr, modulo N
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);

   // Scan from farthest to nearest so the closest match to ptr is the last one written.
   always_comb begin
      int j;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = (int'(ptr) + k) % N;
         if (req[j]) begin
            idx   = IW'(j);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - packet-locking round-robin arbiter feeding one downstream fifo
module fifo_wr_arb
   import fifo_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 128,
   parameter int MAX_BURST  = 8
) (
   input  logic                          clk,
   input  logic                          arst,
   input  logic                          srst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   input  logic                          fifo_almost_full,
   output logic                          fifo_wr,
   output logic [DATA_WIDTH-1:0]         fifo_data,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          locked
);

   localparam int IW = $clog2(NUM_REQ);

   state_t                r_state;
   logic [IW-1:0]         r_rr_ptr;
   logic [IW-1:0]         r_grant_id;
   logic [BEAT_CNT_W-1:0] r_beat_cnt;
   logic                  r_fifo_wr;
   logic [DATA_WIDTH-1:0] r_fifo_data;

   logic                  w_space_ok;
   logic                  w_found;
   logic [IW-1:0]         w_pick;
   logic [IW-1:0]         w_sel;
   logic [IW-1:0]         w_next;
   logic                  w_grant;
   logic                  w_xfer;
   logic                  w_last;
   logic                  w_burst_end;
   logic [DATA_WIDTH-1:0] w_beat;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr_pick (
      .req   (req_valid),
      .ptr   (r_rr_ptr),
      .idx   (w_pick),
      .found (w_found)
   );

   // A write already in flight consumes the last free slot when almost_full is set.
   assign w_space_ok  = !fifo_full && !(fifo_almost_full && r_fifo_wr);
   assign w_sel       = (r_state == LOCK) ? r_grant_id : w_pick;
   assign w_grant     = w_space_ok && ((r_state == LOCK) || w_found) && !arst && !srst;
   assign w_xfer      = w_grant && req_valid[w_sel];
   assign w_last      = req_last[w_sel];
   assign w_beat      = req_data[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
   assign w_next      = (w_sel == IW'(NUM_REQ - 1)) ? '0 : w_sel + IW'(1);
   assign w_burst_end = (r_beat_cnt + BEAT_CNT_W'(1)) == BEAT_CNT_W'(MAX_BURST);

   always_comb begin
      req_ready = '0;
      if (w_grant) req_ready[w_sel] = 1'b1;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant_id  <= '0;
         r_beat_cnt  <= '0;
         r_fifo_wr   <= 1'b0;
         r_fifo_data <= '0;
      end else if (srst) begin
         r_state     <= IDLE;
         r_rr_ptr    <= '0;
         r_grant_id  <= '0;
         r_beat_cnt  <= '0;
         r_fifo_wr   <= 1'b0;
         r_fifo_data <= '0;
      end else begin
         r_fifo_wr <= w_xfer;
         if (w_xfer) begin
            r_fifo_data <= w_beat;
            case (r_state)
               IDLE: begin
                  if (!w_last && (MAX_BURST > 1)) begin
                     r_state    <= LOCK;
                     r_grant_id <= w_sel;
                     r_beat_cnt <= BEAT_CNT_W'(1);
                  end else begin
                     r_rr_ptr <= w_next;
                  end
               end
               LOCK: begin
                  // A burst-limit exit releases the grant but not the packet; the owner re-arbitrates.
                  if (w_last || w_burst_end) begin
                     r_state    <= IDLE;
                     r_rr_ptr   <= w_next;
                     r_beat_cnt <= '0;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BEAT_CNT_W'(1);
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign fifo_wr   = r_fifo_wr;
   assign fifo_data = r_fifo_data;
   assign grant_id  = r_grant_id;
   assign locked    = (r_state == LOCK);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - directed and randomized bench for fifo_wr_arb against a behavioural model
module tb_fifo_wr_arb;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            arst;
   logic            srst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            fifo_full;
   logic            fifo_almost_full;
   logic            fifo_wr;
   logic [DW-1:0]   fifo_data;
   logic [1:0]      grant_id;
   logic            locked;

   fifo_wr_arb #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk              (clk),
      .arst             (arst),
      .srst             (srst),
      .req_valid        (req_valid),
      .req_last         (req_last),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .fifo_full        (fifo_full),
      .fifo_almost_full (fifo_almost_full),
      .fifo_wr          (fifo_wr),
      .fifo_data        (fifo_data),
      .grant_id         (grant_id),
      .locked           (locked)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model: packet ownership, rotating priority and a one-deep write pipe.
   bit            m_lock;
   int            m_owner;
   int            m_cnt;
   int            m_rr;
   bit            m_wr;
   logic [DW-1:0] m_data;
   bit            m_xfer;
   int            m_xid;
   logic [N-1:0]  got_ready;

   int seqn[N];
   int rem[N];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] model_ready();
      bit space;
      space = !fifo_full && !(fifo_almost_full && m_wr);
      if (arst || srst || !space) return '0;
      if (m_lock) return N'(1) << m_owner;
      for (int k = 0; k < N; k++)
         if (req_valid[(m_rr + k) % N]) return N'(1) << ((m_rr + k) % N);
      return '0;
   endfunction

   task automatic model_reset();
      m_lock  = 1'b0;
      m_owner = 0;
      m_cnt   = 0;
      m_rr    = 0;
      m_wr    = 1'b0;
      m_data  = '0;
   endtask

   task automatic fill_data();
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom);
   endtask

   task automatic cycle();
      logic [N-1:0] er;
      bit rst;
      #1;
      er        = model_ready();
      got_ready = req_ready;
      chk("req_ready", req_ready, er);
      m_xfer = 1'b0;
      for (int i = 0; i < N; i++)
         if (er[i] && req_valid[i]) begin
            m_xfer = 1'b1;
            m_xid  = i;
         end
      rst = srst;
      @(posedge clk);
      if (rst) begin
         model_reset();
         m_xfer = 1'b0;
      end else begin
         m_wr = m_xfer;
         if (m_xfer) begin
            m_data = req_data[m_xid*DW +: DW];
            if (!m_lock) begin
               if (!req_last[m_xid] && MB > 1) begin
                  m_lock  = 1'b1;
                  m_owner = m_xid;
                  m_cnt   = 1;
               end else begin
                  m_rr = (m_xid + 1) % N;
               end
            end else begin
               m_cnt++;
               if (req_last[m_xid] || m_cnt == MB) begin
                  m_lock = 1'b0;
                  m_rr   = (m_owner + 1) % N;
                  m_cnt  = 0;
               end
            end
         end
      end
      #1;
      chk("fifo_wr", fifo_wr, m_wr);
      if (m_wr) chk("fifo_data", fifo_data, m_data);
      chk("locked", locked, m_lock);
      if (m_lock) chk("grant_id", grant_id, 64'(m_owner));
   endtask

   task automatic set_in(input logic [N-1:0] v, input logic [N-1:0] l);
      req_valid = v;
      req_last  = l;
      fill_data();
   endtask

   task automatic do_reset();
      arst             = 1'b1;
      srst             = 1'b0;
      fifo_full        = 1'b0;
      fifo_almost_full = 1'b0;
      set_in('1, '1);
      #1;
      chk("ready_in_reset", req_ready, 0);
      chk("rst_fifo_wr", fifo_wr, 0);
      chk("rst_locked", locked, 0);
      chk("rst_fifo_data", fifo_data, 0);
      @(posedge clk);
      #1;
      arst = 1'b0;
      model_reset();
      set_in('0, '0);
   endtask

   int exp_ids[12] = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 3, 1, 1};
   logic [N-1:0] exp_rr[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

   initial begin
      int sent;
      do_reset();

      // Single-beat packets from everyone rotate one grant per cycle.
      set_in(4'b1111, 4'b1111);
      for (int k = 0; k < 5; k++) begin
         fill_data();
         cycle();
         chk("rr_order", got_ready, exp_rr[k]);
         chk("rr_wr_next", fifo_wr, 1);
      end

      // A locked packet from 2 keeps 0 waiting until its last beat.
      do_reset();
      set_in(4'b0100, 4'b0000);
      cycle();
      chk("lock_grant", grant_id, 2);
      chk("lock_locked", locked, 1);
      set_in(4'b0101, 4'b0000);
      cycle();
      chk("lock_beat2", got_ready, 4'b0100);
      set_in(4'b0101, 4'b0100);
      cycle();
      chk("lock_beat3", got_ready, 4'b0100);
      chk("lock_release", locked, 0);
      set_in(4'b0101, 4'b0001);
      cycle();
      chk("after_lock", got_ready, 4'b0001);

      // Burst limit interleaves a 10-beat packet from 1 with single beats from 3.
      do_reset();
      sent = 0;
      for (int k = 0; k < 12; k++) begin
         set_in({1'b1, 1'b0, (sent < 10) ? 1'b1 : 1'b0, 1'b0}, {1'b1, 1'b0, (sent == 9) ? 1'b1 : 1'b0, 1'b0});
         if (k == 0) req_valid[3] = 1'b0;
         cycle();
         chk("burst_seq", got_ready, N'(1) << exp_ids[k]);
         if (m_xfer && m_xid == 1) sent++;
      end
      chk("burst_total", sent, 10);

      // Almost-full plus an in-flight write blocks exactly one cycle.
      do_reset();
      set_in(4'b0001, 4'b0001);
      cycle();
      fifo_almost_full = 1'b1;
      cycle();
      chk("afull_block", got_ready, 4'b0000);
      cycle();
      chk("afull_accept", got_ready, 4'b0001);
      cycle();
      chk("afull_reblock", got_ready, 4'b0000);
      fifo_almost_full = 1'b0;

      // Full mid-packet stalls the owner with grant held.
      do_reset();
      set_in(4'b0001, 4'b0000);
      cycle();
      fifo_full = 1'b1;
      set_in(4'b1111, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("full_stall", got_ready, 4'b0000);
         chk("full_locked", locked, 1);
         chk("full_grant", grant_id, 0);
      end
      fifo_full = 1'b0;
      cycle();
      chk("full_resume", got_ready, 4'b0001);

      // Asynchronous reset abandons a locked packet.
      do_reset();
      set_in(4'b0100, 4'b0000);
      cycle();
      cycle();
      arst = 1'b1;
      #1;
      chk("arst_ready", req_ready, 0);
      chk("arst_locked", locked, 0);
      chk("arst_wr", fifo_wr, 0);
      #1;
      arst = 1'b0;
      model_reset();
      set_in(4'b1110, 4'b1110);
      cycle();
      chk("arst_next_grant", got_ready, 4'b0010);

      // Synchronous reset does the same at the clock edge.
      set_in(4'b1000, 4'b0000);
      cycle();
      srst = 1'b1;
      cycle();
      chk("srst_locked", locked, 0);
      chk("srst_wr", fifo_wr, 0);
      srst = 1'b0;

      // Randomized traffic: packet generators per requester, random backpressure and rare srst.
      for (int i = 0; i < N; i++) begin
         seqn[i] = 0;
         rem[i]  = 1 + int'($urandom % 10);
      end
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            req_valid[i]         = ($urandom % 100) < 60;
            req_last[i]          = (rem[i] == 1);
            req_data[i*DW +: DW] = {4'(i), 12'(seqn[i])};
         end
         fifo_full        = ($urandom % 100) < 10;
         fifo_almost_full = ($urandom % 100) < 25;
         srst             = ($urandom % 500) == 0;
         cycle();
         if (m_xfer) begin
            seqn[m_xid]++;
            rem[m_xid]--;
            if (rem[m_xid] == 0) rem[m_xid] = 1 + int'($urandom % 10);
         end
      end
      srst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
